puf_seq_ctrl: RTL and testbench
===============================

Name: puf_seq_ctrl

Overview:
- Sequencer for the ring-oscillator PUF bit cell: on `start`, walks a challenge sequence and runs one race evaluation per challenge.
- Each evaluation: clear the bit cell, enable the ROs, wait for `finish`, then capture the response bit.
- Responses are assembled into an N_BITS response word for the top-level/TinyTapeout I/O wrapper.
- Owns the bit cell's `en`, challenge and local clear; adds a watchdog against a race that never resolves.

Parameters:
- N_BITS, 8, response bits per run (1..32)
- CHALL_STEP, 8'd37, odd increment between consecutive challenges (mod 256)
- TIMEOUT, 16'd4095, max cycles in EVAL before abort
- CLR_CYC, 2, cycles `puf_clr` is held before enabling

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  pulse; begins a run when idle
- seed  in  8  first challenge, sampled on accepted start
- puf_chall  out  8  challenge to bit cell
- puf_en  out  1  RO enable to bit cell
- puf_clr  out  1  active-high local clear of counters/arbiter
- puf_resp  in  1  race result from bit cell
- puf_finish  in  1  race complete from bit cell
- resp_word  out  N_BITS  assembled response, bit i = challenge i
- busy  out  1  high from accepted start until DONE
- done  out  1  one-cycle pulse at end of run
- timeout_err  out  1  sticky; set on watchdog abort, cleared on next accepted start

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0; internal counters 0.
- FSM states: IDLE, CLEAR, EVAL, CAPTURE, NEXT, DONE.
- IDLE:
  - `start`=1 → latch seed into chall_reg; clear bit_idx, resp_word and timeout_err; busy=1; go to CLEAR.
  - `start` while busy is ignored.
- CLEAR: puf_clr=1 and puf_en=0 for exactly CLR_CYC cycles, then go to EVAL.
- EVAL:
  - puf_en=1; watchdog increments each cycle.
  - `puf_finish`=1 → go to CAPTURE.
  - Watchdog reaches TIMEOUT without finish → timeout_err=1, puf_en=0, go to DONE; resp_word keeps the bits captured so far, higher bits stay 0.
  - finish and timeout in the same cycle: finish wins.
- CAPTURE (1 cycle):
  - puf_en=0; resp_word[bit_idx] ← puf_resp, sampled in the cycle finish was seen.
  - Registered copy; no combinational path from puf_resp to resp_word.
- NEXT (1 cycle):
  - bit_idx == N_BITS-1 → DONE.
  - Otherwise bit_idx+1, chall_reg ← chall_reg + CHALL_STEP (8-bit wrap, no saturation), watchdog cleared, go to CLEAR.
- DONE: done=1 for one cycle, busy=0, go to IDLE. resp_word is held until the next accepted start.
- puf_chall = chall_reg throughout. It changes only in NEXT, never while puf_en=1.
- Latency per bit, with finish after F cycles in EVAL: CLR_CYC + F + 2 cycles. Whole run = N_BITS × that + 1, counted from the start cycle to the done pulse.
- Reset mid-run aborts immediately; no done pulse.
- puf_finish outside EVAL is ignored.

Optional Feature:
- Macro: PUF_MAJ_VOTE_EN.
- Defined:
  - Each challenge is evaluated 3 times (CLEAR→EVAL→CAPTURE ×3) before NEXT; the stored bit is the majority of the 3 samples.
  - A 2-bit vote counter and a 2-bit ones tally are added.
  - A timeout on any repeat aborts the run as above.
  - Latency triples.
- Undefined: single evaluation per challenge, exactly as described above.

Decomposition:
- Shared package `puf_pkg` holds:
  - FSM state typedef (3-bit enum)
  - default CHALL_STEP, TIMEOUT and CLR_CYC constants
  - CHALL_W = 8
- One natural sub-module: `puf_watchdog`, a loadable down-counter with clear and an expired flag, reused for both the CLEAR hold and the EVAL timeout.

Test Plan:
- Basic run: N_BITS=8, seed=8'h00, model returns resp = parity(chall), finish 20 cycles after en.
  - Required: chall sequence 00,25,4A,6F,94,B9,DE,03.
  - resp_word matches the model; done pulses once, 8×24+1 cycles after start.
- Wrap-around: seed=8'hF0 → second challenge 8'h15; no X, no saturation.
- Timeout: TIMEOUT=16, finish never asserted on bit 3.
  - timeout_err=1; resp_word[2:0] captured, [7:3]=0; done pulse; puf_en=0.
  - timeout_err clears on next start.
- Reset mid-EVAL: rst low while puf_en=1.
  - Immediately puf_en=0, busy=0, resp_word=0, no done.
  - Next start runs normally.
- Simultaneous/ignored events:
  - finish in the same cycle the watchdog expires → bit captured, no error.
  - start while busy → no restart, seed not re-sampled.
- PUF_MAJ_VOTE_EN: model returns samples 1,0,1 for bit 0 → bit 0 = 1; samples 0,0,1 → 0. Run length is 3× the baseline.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared types and default constants for the ring-oscillator PUF sequencer.
package puf_pkg;

  localparam int          CHALL_W        = 8;
  localparam int          WD_W           = 16;
  localparam logic [7:0]  CHALL_STEP_DEF = 8'd37;
  localparam logic [15:0] TIMEOUT_DEF    = 16'd4095;
  localparam int          CLR_CYC_DEF    = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_EVAL,
    S_CAPTURE,
    S_NEXT,
    S_DONE
  } state_e;

endpackage

// File: rtl/puf_watchdog.sv
// Loadable down-counter with clear; flags expiry when the count sits at zero.
module puf_watchdog
  import puf_pkg::*;
#(
  parameter int W = WD_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_loadVal,
  input  logic         i_clear,
  input  logic         i_tick,
  output logic         o_expired
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_tick && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/puf_seq_ctrl.sv
// Challenge sequencer for the RO PUF bit cell: clear, race, capture per challenge.
// Define PUF_MAJ_VOTE_EN to store the majority of three evaluations per challenge.
module puf_seq_ctrl
  import puf_pkg::*;
#(
  parameter int          N_BITS     = 8,
  parameter logic [7:0]  CHALL_STEP = CHALL_STEP_DEF,
  parameter logic [15:0] TIMEOUT    = TIMEOUT_DEF,
  parameter int          CLR_CYC    = CLR_CYC_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [CHALL_W-1:0] i_seed,
  output logic [CHALL_W-1:0] o_puf_chall,
  output logic               o_puf_en,
  output logic               o_puf_clr,
  input  logic               i_puf_resp,
  input  logic               i_puf_finish,
  output logic [N_BITS-1:0]  o_resp_word,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_timeout_err
);

  localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  state_e             r_state;
  logic [CHALL_W-1:0] r_challReg;
  logic [IDX_W-1:0]   r_bitIdx;
  logic [N_BITS-1:0]  r_respWord;
  logic               r_sample;
  logic               r_pufEn;
  logic               r_pufClr;
  logic               r_busy;
  logic               r_done;
  logic               r_timeoutErr;
`ifdef PUF_MAJ_VOTE_EN
  logic [1:0]         r_vote;
  logic [1:0]         r_ones;
`endif

  logic               w_wdLoad;
  logic [WD_W-1:0]    w_wdLoadVal;
  logic               w_wdClear;
  logic               w_wdTick;
  logic               w_wdExpired;
  logic               w_lastBit;

  assign w_lastBit = (r_bitIdx == IDX_W'(N_BITS - 1));

  // One counter serves both the clear hold and the race timeout; the load value follows the phase.
  always_comb begin
    w_wdLoad = 1'b0;
    case (r_state)
      S_IDLE:    w_wdLoad = i_start;
      S_CLEAR:   w_wdLoad = w_wdExpired;
      S_NEXT:    w_wdLoad = !w_lastBit;
`ifdef PUF_MAJ_VOTE_EN
      S_CAPTURE: w_wdLoad = (r_vote != 2'd2);
`endif
      default:   w_wdLoad = 1'b0;
    endcase
  end

  assign w_wdLoadVal = (r_state == S_CLEAR) ? (TIMEOUT - 16'd1) : 16'(CLR_CYC - 1);
  assign w_wdClear   = (r_state == S_NEXT) || (r_state == S_DONE);
  assign w_wdTick    = (r_state == S_CLEAR) || (r_state == S_EVAL);

  puf_watchdog #(.W(WD_W)) u_watchdog (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (w_wdLoad),
    .i_loadVal (w_wdLoadVal),
    .i_clear   (w_wdClear),
    .i_tick    (w_wdTick),
    .o_expired (w_wdExpired)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_challReg   <= '0;
      r_bitIdx     <= '0;
      r_respWord   <= '0;
      r_sample     <= 1'b0;
      r_pufEn      <= 1'b0;
      r_pufClr     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_timeoutErr <= 1'b0;
`ifdef PUF_MAJ_VOTE_EN
      r_vote       <= '0;
      r_ones       <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_challReg   <= i_seed;
            r_bitIdx     <= '0;
            r_respWord   <= '0;
            r_timeoutErr <= 1'b0;
            r_busy       <= 1'b1;
            r_pufClr     <= 1'b1;
`ifdef PUF_MAJ_VOTE_EN
            r_vote       <= '0;
            r_ones       <= '0;
`endif
            r_state      <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (w_wdExpired) begin
            r_pufClr <= 1'b0;
            r_pufEn  <= 1'b1;
            r_state  <= S_EVAL;
          end
        end
        S_EVAL: begin
          // A finish in the expiry cycle still counts as a resolved race.
          if (i_puf_finish) begin
            r_sample <= i_puf_resp;
            r_pufEn  <= 1'b0;
            r_state  <= S_CAPTURE;
          end else if (w_wdExpired) begin
            r_timeoutErr <= 1'b1;
            r_pufEn      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        S_CAPTURE: begin
`ifdef PUF_MAJ_VOTE_EN
          if (r_vote == 2'd2) begin
            r_respWord[r_bitIdx] <= ((r_ones + {1'b0, r_sample}) >= 2'd2);
            r_vote               <= '0;
            r_ones               <= '0;
            r_state              <= S_NEXT;
          end else begin
            r_vote   <= r_vote + 2'd1;
            r_ones   <= r_ones + {1'b0, r_sample};
            r_pufClr <= 1'b1;
            r_state  <= S_CLEAR;
          end
`else
          r_respWord[r_bitIdx] <= r_sample;
          r_state              <= S_NEXT;
`endif
        end
        S_NEXT: begin
          if (w_lastBit) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_bitIdx   <= r_bitIdx + IDX_W'(1);
            r_challReg <= r_challReg + CHALL_STEP;
            r_pufClr   <= 1'b1;
            r_state    <= S_CLEAR;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_puf_chall   = r_challReg;
  assign o_puf_en      = r_pufEn;
  assign o_puf_clr     = r_pufClr;
  assign o_resp_word   = r_respWord;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_timeout_err = r_timeoutErr;

endmodule

// File: tb/tb_puf_seq_ctrl.sv
// Directed bench for puf_seq_ctrl: two instances (default timeout, TIMEOUT=16) driven by small bit-cell models.
`timescale 1ns/1ps
module tb_puf_seq_ctrl;

`ifdef PUF_MAJ_VOTE_EN
  localparam int PASSES = 3;
`else
  localparam int PASSES = 1;
`endif
  localparam int LIMIT = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       startA, startB;
  logic [7:0] seedA, seedB;
  logic [7:0] challA, challB;
  logic       enA, enB, clrA, clrB;
  logic       respA, respB, finA, finB;
  logic [7:0] wordA, wordB;
  logic       busyA, busyB, doneA, doneB, errA, errB;

  int compared   = 0;
  int mismatched = 0;

  puf_seq_ctrl dutA (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(startA), .i_seed(seedA),
    .o_puf_chall(challA), .o_puf_en(enA), .o_puf_clr(clrA),
    .i_puf_resp(respA), .i_puf_finish(finA), .o_resp_word(wordA),
    .o_busy(busyA), .o_done(doneA), .o_timeout_err(errA)
  );

  puf_seq_ctrl #(.TIMEOUT(16'd16)) dutB (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(startB), .i_seed(seedB),
    .o_puf_chall(challB), .o_puf_en(enB), .o_puf_clr(clrB),
    .i_puf_resp(respB), .i_puf_finish(finB), .o_resp_word(wordB),
    .o_busy(busyB), .o_done(doneB), .o_timeout_err(errB)
  );

  // Bit-cell models: finish after finDelay enabled cycles, response = parity of the challenge.
  int         enCntA, enCntB;
  int         finDelayA = 20;
  int         finDelayB = 5;
  logic       killEnB = 1'b0;
  logic [7:0] killChallB = 8'h00;
  logic [7:0] challLog[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enCntA <= 0;
      enCntB <= 0;
    end else begin
      enCntA <= enA ? enCntA + 1 : 0;
      enCntB <= enB ? enCntB + 1 : 0;
    end
  end

  always @(posedge clk) begin
    if (enA && enCntA == 0) challLog.push_back(challA);
  end

  assign finA  = enA && (enCntA == finDelayA - 1);
  assign finB  = enB && (enCntB == finDelayB - 1) && !(killEnB && challB == killChallB);
  assign respB = ^challB;

`ifdef PUF_MAJ_VOTE_EN
  // Flip one of three samples: parity-1 challenges see 1,0,1 and parity-0 see 0,0,1.
  int         passA;
  logic [7:0] lastChallA;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      passA      <= 0;
      lastChallA <= 8'hFF;
    end else if (enA && enCntA == 0) begin
      passA      <= (passA < 2 && challA == lastChallA) ? passA + 1 : 0;
      lastChallA <= challA;
    end
  end
  assign respA = (^challA) ^ (passA == ((^challA) ? 1 : 2));
`else
  assign respA = ^challA;
`endif

  function automatic logic [7:0] expResp(input logic [7:0] seed, input int nValid);
    logic [7:0] c;
    logic [7:0] r;
    c = seed;
    r = 8'h00;
    for (int i = 0; i < nValid; i++) begin
      r[i] = ^c;
      c = c + 8'd37;
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Start a run on instance sel, optionally re-pulse start mid-run, and count cycles until done.
  task automatic applyStimulus(input int sel, input logic [7:0] seed, input int reStartAt,
                               output int cycles);
    @(posedge clk); #1;
    if (sel == 0) begin challLog.delete(); seedA = seed; startA = 1'b1; end
    else begin seedB = seed; startB = 1'b1; end
    @(posedge clk); #1;
    startA = 1'b0;
    startB = 1'b0;
    cycles = 1;
    checkOutput("busyAfterStart", (sel == 0) ? busyA : busyB, 1);
    checkOutput("errClearOnStart", (sel == 0) ? errA : errB, 0);
    while (!((sel == 0) ? doneA : doneB) && cycles < LIMIT) begin
      if (cycles == reStartAt) begin
        if (sel == 0) begin seedA = 8'h80; startA = 1'b1; end
        else begin seedB = 8'h80; startB = 1'b1; end
      end else begin
        startA = 1'b0;
        startB = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    startA = 1'b0;
    startB = 1'b0;
    checkOutput("doneSeen", (sel == 0) ? doneA : doneB, 1);
    checkOutput("busyAtDone", (sel == 0) ? busyA : busyB, 0);
    @(posedge clk); #1;
    checkOutput("donePulseOnce", (sel == 0) ? doneA : doneB, 0);
  endtask

  initial begin
    int         cyc;
    int         waitCnt;
    logic       sawDone;
    logic [7:0] basicChall [8];
    basicChall = '{8'h00, 8'h25, 8'h4A, 8'h6F, 8'h94, 8'hB9, 8'hDE, 8'h03};

    rst_n  = 1'b0;
    startA = 1'b0;
    startB = 1'b0;
    seedA  = 8'h00;
    seedB  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstEn", enA, 0);
    checkOutput("rstClr", clrA, 0);
    checkOutput("rstBusy", busyA, 0);
    checkOutput("rstDone", doneA, 0);
    checkOutput("rstErr", errA, 0);
    checkOutput("rstWord", wordA, 0);
    checkOutput("rstChall", challA, 0);
    rst_n = 1'b1;

    $display("[TB] basic run, seed 00, finish after 20");
    finDelayA = 20;
    applyStimulus(0, 8'h00, -1, cyc);
    checkOutput("basicCycles", cyc, 8 * (PASSES * 23 + 1) + 1);
    checkOutput("basicWord", wordA, 8'h36);
    checkOutput("basicErr", errA, 0);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("basicChall%0d", i), challLog[i * PASSES], basicChall[i]);

    $display("[TB] wrap-around, seed F0");
    finDelayA = 3;
    applyStimulus(0, 8'hF0, -1, cyc);
    checkOutput("wrapChall0", challLog[0], 8'hF0);
    checkOutput("wrapChall1", challLog[PASSES], 8'h15);
    checkOutput("wrapWord", wordA, expResp(8'hF0, 8));
    checkOutput("wrapCycles", cyc, 8 * (PASSES * 6 + 1) + 1);

    $display("[TB] start while busy is ignored");
    applyStimulus(0, 8'h10, 10, cyc);
    checkOutput("busyStartChall0", challLog[0], 8'h10);
    checkOutput("busyStartWord", wordA, expResp(8'h10, 8));
    checkOutput("busyStartCycles", cyc, 8 * (PASSES * 6 + 1) + 1);

    $display("[TB] reset mid-EVAL");
    finDelayA = 5;
    @(posedge clk); #1;
    seedA  = 8'h00;
    startA = 1'b1;
    @(posedge clk); #1;
    startA  = 1'b0;
    waitCnt = 0;
    while (!(enA && challA == 8'h4A) && waitCnt < 500) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    checkOutput("reachEval2", enA && challA == 8'h4A, 1);
    checkOutput("wordBeforeReset", wordA, 8'h02);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstEn", enA, 0);
    checkOutput("midRstBusy", busyA, 0);
    checkOutput("midRstWord", wordA, 0);
    sawDone = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      sawDone = sawDone | doneA;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    sawDone = sawDone | doneA;
    checkOutput("midRstNoDone", sawDone, 0);
    finDelayA = 20;
    applyStimulus(0, 8'h00, -1, cyc);
    checkOutput("afterRstWord", wordA, 8'h36);
    checkOutput("afterRstCycles", cyc, 8 * (PASSES * 23 + 1) + 1);

    $display("[TB] watchdog abort on bit 3 (TIMEOUT=16)");
    finDelayB  = 5;
    killEnB    = 1'b1;
    killChallB = 8'h6F;
    applyStimulus(1, 8'h00, -1, cyc);
    checkOutput("toErr", errB, 1);
    checkOutput("toWord", wordB, 8'h06);
    checkOutput("toEn", enB, 0);
    checkOutput("toCycles", cyc, 3 * (PASSES * 8 + 1) + 19);

    $display("[TB] finish on the expiry cycle");
    killEnB   = 1'b0;
    finDelayB = 16;
    applyStimulus(1, 8'h00, -1, cyc);
    checkOutput("tieErr", errB, 0);
    checkOutput("tieWord", wordB, 8'h36);
    checkOutput("tieCycles", cyc, 8 * (PASSES * 19 + 1) + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
